// File: rtl/core_reg_bank_pkg.sv
// Shared bus definitions for the core data bus: default width and the
// read/write select code space used by both the bus mux and the register bank.
package core_reg_bank_pkg;

    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [3:0] {
        SEL_NONE = 4'd0,
        SEL_ID   = 4'd1,
        SEL_I    = 4'd2,
        SEL_J    = 4'd3,
        SEL_K    = 4'd4,
        SEL_A    = 4'd5,
        SEL_RSV6 = 4'd6,
        SEL_DR   = 4'd7,
        SEL_AC   = 4'd8,
        SEL_R    = 4'd9,
        SEL_SUM  = 4'd10,
        SEL_DRAM = 4'd11,
        SEL_IRAM = 4'd12
    } sel_e;

endpackage

// File: rtl/core_reg_bank_if.sv
// Register bank connection bundle: bus capture/ALU controls in, register values out.
// master drives the controls and observes the registers; slave is the register bank.
interface core_reg_bank_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] busout;
    logic [3:0]        write_en;
    logic [2:0]        inc_en;
    logic [DATA_W-1:0] alu_out;
    logic              alu_we;
    logic              ac_clr;

    logic [DATA_W-1:0] id;
    logic [DATA_W-1:0] i;
    logic [DATA_W-1:0] j;
    logic [DATA_W-1:0] k;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] dr;
    logic [DATA_W-1:0] ac;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] sum;
    logic              z_flag;

    modport master (
        output busout, write_en, inc_en, alu_out, alu_we, ac_clr,
        input  id, i, j, k, a, dr, ac, r, sum, z_flag
    );

    modport slave (
        input  busout, write_en, inc_en, alu_out, alu_we, ac_clr,
        output id, i, j, k, a, dr, ac, r, sum, z_flag
    );
endinterface

// File: rtl/core_reg_bank_inc_reg.sv
// Loop counter register: async reset, bus load, wrapping increment; load wins over increment.
module inc_reg #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              inc,
    output logic [DATA_W-1:0] value
);
    logic [DATA_W-1:0] value_q;
    logic [DATA_W-1:0] value_d;

    // Next value: load, else increment (wraps naturally), else hold.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (inc) begin
            value_d = value_q + DATA_W'(1);
        end
    end

    // Counter state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
endmodule

// File: rtl/core_reg_bank.sv
// Per-core register bank feeding the core data bus and capturing busout.
// Optional feature: define REG_BANK_ZFLAG_EN for a registered zero flag on ac.
module core_reg_bank
    import core_reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned CORE_ID = 0
) (
    input logic              clock,
    input logic              reset,
    core_reg_bank_if.slave   bus
);
    logic [DATA_W-1:0] a_q, dr_q, ac_q, r_q, sum_q;
    logic [DATA_W-1:0] ac_d;
    logic              ac_wr;

    inc_reg #(.DATA_W(DATA_W)) u_i (
        .clock    (clock),
        .reset    (reset),
        .load     (bus.write_en == SEL_I),
        .load_val (bus.busout),
        .inc      (bus.inc_en[0]),
        .value    (bus.i)
    );

    inc_reg #(.DATA_W(DATA_W)) u_j (
        .clock    (clock),
        .reset    (reset),
        .load     (bus.write_en == SEL_J),
        .load_val (bus.busout),
        .inc      (bus.inc_en[1]),
        .value    (bus.j)
    );

    inc_reg #(.DATA_W(DATA_W)) u_k (
        .clock    (clock),
        .reset    (reset),
        .load     (bus.write_en == SEL_K),
        .load_val (bus.busout),
        .inc      (bus.inc_en[2]),
        .value    (bus.k)
    );

    // ac source select: bus write > ALU load > clear; losers are dropped.
    always_comb begin
        ac_d  = ac_q;
        ac_wr = 1'b1;
        if (bus.write_en == SEL_AC) begin
            ac_d = bus.busout;
        end else if (bus.alu_we) begin
            ac_d = bus.alu_out;
        end else if (bus.ac_clr) begin
            ac_d = '0;
        end else begin
            ac_wr = 1'b0;
        end
    end

    // Plain bus-writable registers plus ac; unselected codes leave everything unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            dr_q  <= '0;
            ac_q  <= '0;
            r_q   <= '0;
            sum_q <= '0;
        end else begin
            if (bus.write_en == SEL_A)   a_q   <= bus.busout;
            if (bus.write_en == SEL_DR)  dr_q  <= bus.busout;
            if (bus.write_en == SEL_R)   r_q   <= bus.busout;
            if (bus.write_en == SEL_SUM) sum_q <= bus.busout;
            if (ac_wr)                   ac_q  <= ac_d;
        end
    end

`ifdef REG_BANK_ZFLAG_EN
    logic z_q;

    // Zero flag tracks the value written into ac, only on ac write edges.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            z_q <= 1'b0;
        end else if (ac_wr) begin
            z_q <= (ac_d == '0);
        end
    end

    assign bus.z_flag = z_q;
`else
    assign bus.z_flag = 1'b0;
`endif

    assign bus.id  = DATA_W'(CORE_ID);
    assign bus.a   = a_q;
    assign bus.dr  = dr_q;
    assign bus.ac  = ac_q;
    assign bus.r   = r_q;
    assign bus.sum = sum_q;
endmodule
